imem_load_controller: RTL
=========================

Name: imem_load_controller

Overview:
- Sequences the single-port, word-organised instruction memory, sharing it between two requesters: the fetch stage (read) and a program loader (write).
- The loader streams words in over a valid/ready handshake. While a load runs, the controller owns the memory port, stalls fetch and holds the core in reset.
- Sits between IF, the boot/debug loader and the instruction memory array.

Parameters:
- address_bits, 12, byte-address width; memory depth is 2**(address_bits-2) words.
- data_width, 32, instruction/word width.
- NOP_WORD, 32'h00000013, value returned to fetch while it is stalled (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_addr  in  address_bits  byte address from PC.
- fetch_instr  out  data_width  instruction to IF.
- fetch_stall  out  1  PC/IF hold request.
- fetch_misaligned  out  1  fetch_addr[1:0] != 0.
- load_start  in  1  one-cycle pulse that starts a load.
- load_base  in  address_bits  byte start address; bits [1:0] are ignored.
- load_count  in  address_bits-1  number of words to load (0 to depth).
- load_valid  in  1  load_data is valid.
- load_data  in  data_width  word to write.
- load_ready  out  1  controller accepts load_data this cycle.
- load_busy  out  1  a load is in progress.
- load_done  out  1  one-cycle pulse when a load completes.
- core_hold  out  1  holds the pipeline in reset.
- mem_addr  out  address_bits-2  word index to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  data_width  write data.
- mem_rdata  in  data_width  combinational read data from memory.

Behaviour:
- FSM states: RUN, LOAD, DONE. Reset moves to RUN.
- Reset values: fetch_stall=0, load_ready=0, load_busy=0, load_done=0, core_hold=0, mem_we=0, word pointer=0, remaining count=0. Memory contents are not cleared by reset.
- RUN:
  - mem_addr = fetch_addr[address_bits-1:2]; fetch_instr = mem_rdata. This path is combinational, with zero-cycle latency.
  - fetch_stall=0; load_ready=0.
  - load_valid is ignored in RUN.
- RUN to LOAD: on load_start=1 with load_count!=0. The next cycle latches ptr = load_base[address_bits-1:2] and remaining = load_count.
- RUN to DONE: on load_start=1 with load_count=0. No writes occur.
- LOAD:
  - load_busy=1, core_hold=1, fetch_stall=1, fetch_instr=NOP_WORD, load_ready=1.
  - mem_addr = ptr; mem_we = load_valid; mem_wdata = load_data.
  - Each accepted beat (load_valid & load_ready) writes that cycle, then ptr+1 and remaining-1.
  - ptr wraps modulo depth: depth-1 goes to 0.
  - The beat that takes remaining from 1 to 0 moves the FSM to DONE.
  - load_start is ignored in LOAD.
  - A cycle with no beat changes no state.
- DONE (one cycle):
  - load_done=1, load_busy=0, load_ready=0.
  - core_hold=1 and fetch_stall=1 stay asserted this cycle, so the core leaves reset one cycle after the final write.
  - Next state is RUN, unconditionally.
- fetch_misaligned = |fetch_addr[1:0] in every state. It is a flag only; the word is still fetched with bits [1:0] truncated.
- Simultaneous load_start and fetch in RUN: the fetch is served that cycle; the load takes the port from the next cycle.
- Reset during LOAD or DONE: returns to RUN immediately. Words already written remain in memory; no load_done pulse is generated.
- load_count = depth: every word is written exactly once; ptr ends at its start value.

Optional Feature:
- Macro: IMEM_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum [data_width-1:0]: a modular sum of all words accepted in the current load.
  - It clears to 0 on the cycle the FSM enters LOAD and on reset.
  - It is held stable from DONE until the next load starts.
  - For load_count=0 it reads 0.
- Undefined: the port and adder are absent. All other behaviour is identical.

Test Plan:
- Reset, then fetch_addr=0x008 with mem word[2]=0xDEADBEEF -> same cycle: fetch_instr=0xDEADBEEF, mem_addr=2, fetch_stall=0, core_hold=0.
- load_start with base=0x010, count=3, beats 0x11,0x22,0x33 with a one-cycle valid gap -> writes to words 4,5,6 only on valid cycles; fetch_instr=0x00000013 throughout; load_done pulses once, the cycle after the 3rd beat; checksum=0x66; RUN on the following cycle.
- base=0xFFC, count=2 (address_bits=12) -> writes to word 1023 then word 0.
- load_start with count=0 -> no mem_we; load_done high exactly one cycle later; back to RUN.
- reset asserted after 1 of 4 beats -> next cycle RUN, load_busy=0, no load_done; word[base] holds the beat, word[base+1] is unchanged.
- fetch_addr=0x006 -> fetch_misaligned=1, mem_addr=1; load_valid pulsed in RUN -> mem_we stays 0.

Source files
------------

// File: rtl/imem_load_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : imem_load_controller
// Description : Shares one single-port, word-organised instruction memory
//               between the fetch stage (read) and a program loader (write).
//               In RUN, fetch owns the port through a zero-latency
//               combinational path. A load_start pulse hands the port to the
//               loader. Words then stream in over a valid/ready handshake.
//               While the load runs, fetch is stalled (it sees NOP_WORD) and
//               the core is held in reset. A one-cycle DONE state then
//               releases the core.
// Revision    : 1.0 - initial release
//
// Optional feature:
//   IMEM_LOAD_CHECKSUM_EN - adds the output load_checksum. This is the
//                           modular sum of all words accepted in the current
//                           load. It clears when a load starts, and holds
//                           from DONE until the next load.
//
// Ports:
//   clk, reset        system clock (rising edge); synchronous active-high reset
//   fetch_addr        byte address from the PC
//   fetch_instr       instruction to IF (NOP_WORD while stalled)
//   fetch_stall       PC/IF hold request
//   fetch_misaligned  fetch_addr[1:0] != 0; flag only
//   load_start        one-cycle pulse that starts a load
//   load_base         byte start address of the load; bits [1:0] are ignored
//   load_count        number of words to load (0 .. depth)
//   load_valid        load_data is valid
//   load_data         word to write
//   load_ready        controller accepts load_data this cycle
//   load_busy         a load is in progress
//   load_done         one-cycle pulse when a load completes
//   load_checksum     (optional) sum of the accepted words
//   core_hold         holds the pipeline in reset
//   mem_addr          word index to the memory
//   mem_we            memory write enable
//   mem_wdata         memory write data
//   mem_rdata         combinational read data from the memory
//------------------------------------------------------------------------------
module imem_load_controller #(
  parameter int                    ADDRESS_BITS = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    reset,
  // fetch side
  input  logic [ADDRESS_BITS-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0]   fetch_instr,
  output logic                    fetch_stall,
  output logic                    fetch_misaligned,
  // loader side
  input  logic                    load_start,
  input  logic [ADDRESS_BITS-1:0] load_base,
  input  logic [ADDRESS_BITS-2:0] load_count,
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_data,
  output logic                    load_ready,
  output logic                    load_busy,
  output logic                    load_done,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0]   load_checksum,
`endif
  // core and memory side
  output logic                    core_hold,
  output logic [ADDRESS_BITS-3:0] mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int c_WORD_BITS = ADDRESS_BITS - 2;  // word index width
  localparam int c_CNT_BITS  = ADDRESS_BITS - 1;  // holds 0 .. depth

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_WORD_BITS-1:0]  r_ptr;
  logic [c_CNT_BITS-1:0]   r_remaining;
  logic                    r_fetch_stall;
  logic                    r_load_ready;
  logic                    r_load_busy;
  logic                    r_load_done;
  logic                    r_core_hold;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   r_checksum;
`endif

  logic                    w_in_load;
  logic                    w_beat;
  logic                    w_last_beat;
  logic                    w_unused;

  assign w_in_load   = (r_state == S_LOAD);
  assign w_beat      = w_in_load & r_load_ready & load_valid;
  assign w_last_beat = (r_remaining == c_CNT_BITS'(1));

  // The low byte-address bits of the load base only select a byte lane.
  // A word-organised memory has no use for them.
  assign w_unused    = &{1'b0, load_base[1:0]};

  //----------------------------------------------------------------------------
  // Control FSM. The status outputs are computed together with the next state,
  // so they are registered and valid for the whole of each state.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_ptr         <= '0;
      r_remaining   <= '0;
      r_fetch_stall <= 1'b0;
      r_load_ready  <= 1'b0;
      r_load_busy   <= 1'b0;
      r_load_done   <= 1'b0;
      r_core_hold   <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      r_checksum    <= '0;
`endif
    end else begin
      case (r_state)
        S_RUN: begin
          // The fetch in this cycle is still served. The loader owns the
          // port from the next cycle on.
          if (load_start) begin
            r_fetch_stall <= 1'b1;
            r_core_hold   <= 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_checksum    <= '0;
`endif
            if (load_count != '0) begin
              r_state      <= S_LOAD;
              r_ptr        <= load_base[ADDRESS_BITS-1:2];
              r_remaining  <= load_count;
              r_load_ready <= 1'b1;
              r_load_busy  <= 1'b1;
            end else begin
              // Empty load: nothing is written, but the handshake still ends
              // with a completion pulse.
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (w_beat) begin
            // The pointer wraps naturally at the memory depth. A full-depth
            // load therefore writes every word once and ends where it began.
            r_ptr       <= r_ptr + c_WORD_BITS'(1);
            r_remaining <= r_remaining - c_CNT_BITS'(1);
`ifdef IMEM_LOAD_CHECKSUM_EN
            r_checksum  <= r_checksum + load_data;
`endif
            if (w_last_beat) begin
              r_state      <= S_DONE;
              r_load_ready <= 1'b0;
              r_load_busy  <= 1'b0;
              r_load_done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          // The core is held for this one extra cycle, so it leaves reset
          // one cycle after the final write.
          r_state       <= S_RUN;
          r_load_done   <= 1'b0;
          r_fetch_stall <= 1'b0;
          r_core_hold   <= 1'b0;
        end

        default: begin
          r_state       <= S_RUN;
          r_fetch_stall <= 1'b0;
          r_load_ready  <= 1'b0;
          r_load_busy   <= 1'b0;
          r_load_done   <= 1'b0;
          r_core_hold   <= 1'b0;
        end
      endcase
    end
  end

  //----------------------------------------------------------------------------
  // Memory port steering. The fetch path is purely combinational.
  //----------------------------------------------------------------------------
  assign mem_addr  = w_in_load ? r_ptr : fetch_addr[ADDRESS_BITS-1:2];
  // A reset arriving mid-load must not let a last stray beat into memory.
  assign mem_we    = w_beat & ~reset;
  assign mem_wdata = load_data;

  assign fetch_instr      = r_fetch_stall ? NOP_WORD : mem_rdata;
  assign fetch_misaligned = |fetch_addr[1:0];

  assign fetch_stall = r_fetch_stall;
  assign load_ready  = r_load_ready;
  assign load_busy   = r_load_busy;
  assign load_done   = r_load_done;
  assign core_hold   = r_core_hold;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign load_checksum = r_checksum;
`endif

endmodule
`default_nettype wire
